// File: rtl/word_cfg_loader_pkg.sv
// Shared constants for the word configuration loader: register selects, FSM encoding and
// word sizing.
package word_cfg_loader_pkg;

    localparam logic [1:0] REG_X  = 2'd0;
    localparam logic [1:0] REG_Y  = 2'd1;
    localparam logic [1:0] REG_AB = 2'd2;
    localparam logic [1:0] REG_CX = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StLoad = 2'd1;
    localparam state_t StDone = 2'd2;

    localparam int unsigned REGS_PER_BLOCK     = 4;
    localparam int unsigned DEFAULT_NUM_BLOCKS = 8;

    function automatic int unsigned bytes_per_word(input int unsigned num_blocks);
        return REGS_PER_BLOCK * num_blocks;
    endfunction

    localparam int unsigned BYTES_PER_WORD = bytes_per_word(DEFAULT_NUM_BLOCKS);

endpackage

// File: rtl/cfg_strobe_gen.sv
// Registers an accepted configuration byte with its target block/register and presents it
// to the word as cfg_in/cfg_addr plus a single one-cycle set_* strobe.
module cfg_strobe_gen
    import word_cfg_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] wr_block,
    input  logic [1:0]        wr_reg,
    output logic [7:0]        cfg_in,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic              set_x,
    output logic              set_y,
    output logic              set_ab,
    output logic              set_cx
);

    logic [3:0]        strobe_d;
    logic [3:0]        strobe_q;
    logic [7:0]        data_q;
    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        strobe_d = '0;
        if (wr_en) begin
            unique case (wr_reg)
                REG_X:   strobe_d[0] = 1'b1;
                REG_Y:   strobe_d[1] = 1'b1;
                REG_AB:  strobe_d[2] = 1'b1;
                REG_CX:  strobe_d[3] = 1'b1;
                default: strobe_d    = '0;
            endcase
        end
    end

    // Data and address hold between writes; only the strobe is cleared every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= '0;
            data_q   <= '0;
            addr_q   <= '0;
        end else begin
            strobe_q <= strobe_d;
            if (wr_en) begin
                data_q <= wr_data;
                addr_q <= wr_block;
            end
        end
    end

    assign cfg_in   = data_q;
    assign cfg_addr = addr_q;
    assign set_x    = strobe_q[0];
    assign set_y    = strobe_q[1];
    assign set_ab   = strobe_q[2];
    assign set_cx   = strobe_q[3];

endmodule

// File: rtl/word_cfg_loader.sv
// Sequencer that loads all config registers of one word from a valid/ready byte stream,
// block 0 X-select first through the last block's CX register.
module word_cfg_loader
    import word_cfg_loader_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        cfg_in,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic              set_x,
    output logic              set_y,
    output logic              set_ab,
    output logic              set_cx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W+1:0] ptr
);

    localparam int unsigned PTR_W = ADDR_W + 2;
    // NUM_BLOCKS is a power of two, so the last byte index is all ones.
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(bytes_per_word(NUM_BLOCKS) - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             busy_q;
    logic             done_q;
    logic             accept;

    assign in_ready = (state_q == StLoad) && !abort;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else if (accept) begin
                    if (ptr_q == PTR_LAST) begin
                        state_d = StDone;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up with state_q exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= (state_d == StLoad);
            done_q  <= (state_d == StDone);
        end
    end

    cfg_strobe_gen #(
        .ADDR_W (ADDR_W)
    ) u_strobe_gen (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .wr_data  (in_data),
        .wr_block (ptr_q[PTR_W-1:2]),
        .wr_reg   (ptr_q[1:0]),
        .cfg_in   (cfg_in),
        .cfg_addr (cfg_addr),
        .set_x    (set_x),
        .set_y    (set_y),
        .set_ab   (set_ab),
        .set_cx   (set_cx)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign ptr  = ptr_q;

endmodule

// File: tb/tb_word_cfg_loader.sv
// Directed bench for word_cfg_loader: full, stalled, aborted, start-ignored and async-reset
// loads, each cycle compared against a small reference of the load sequence.
module tb_word_cfg_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] cfg_in;
    logic [2:0] cfg_addr;
    logic       set_x;
    logic       set_y;
    logic       set_ab;
    logic       set_cx;
    logic       busy;
    logic       done;
    logic [4:0] ptr;

    int errors = 0;
    int checks = 0;

    // Reference: 0 idle, 1 load, 2 done.
    int         m_st;
    logic [4:0] m_ptr;
    logic [7:0] m_byte;
    logic [2:0] m_addr;
    int         n_strobe;
    int         n_done;
    int         n_busy;

    word_cfg_loader #(
        .NUM_BLOCKS (8),
        .ADDR_W     (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfg_in   (cfg_in),
        .cfg_addr (cfg_addr),
        .set_x    (set_x),
        .set_y    (set_y),
        .set_ab   (set_ab),
        .set_cx   (set_cx),
        .busy     (busy),
        .done     (done),
        .ptr      (ptr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_counts();
        n_strobe = 0;
        n_done   = 0;
        n_busy   = 0;
    endtask

    task automatic reset_model();
        m_st   = 0;
        m_ptr  = '0;
        m_byte = '0;
        m_addr = '0;
    endtask

    // Called at a negedge: drive one cycle of inputs, then check outputs at the next negedge.
    task automatic tick(input logic v, input logic [7:0] d, input logic s, input logic a);
        logic       acc;
        logic [4:0] idx;
        in_valid = v;
        in_data  = d;
        start    = s;
        abort    = a;
        #1;
        check_eq("in_ready", in_ready, (m_st == 1) && !a);
        acc = v && (m_st == 1) && !a;
        idx = m_ptr;
        case (m_st)
            0: if (s && !a) begin m_st = 1; m_ptr = '0; end
            1: begin
                if (a) begin
                    m_st  = 0;
                    m_ptr = '0;
                end else if (acc) begin
                    if (m_ptr == 5'd31) begin m_st = 2; m_ptr = '0; end
                    else m_ptr = m_ptr + 5'd1;
                end
            end
            default: m_st = 0;
        endcase
        if (acc) begin
            m_byte = d;
            m_addr = idx[4:2];
        end
        @(negedge clk);
        check_eq("set_x", set_x, acc && (idx[1:0] == 2'd0));
        check_eq("set_y", set_y, acc && (idx[1:0] == 2'd1));
        check_eq("set_ab", set_ab, acc && (idx[1:0] == 2'd2));
        check_eq("set_cx", set_cx, acc && (idx[1:0] == 2'd3));
        check_eq("cfg_in", cfg_in, m_byte);
        check_eq("cfg_addr", cfg_addr, m_addr);
        check_eq("busy", busy, m_st == 1);
        check_eq("done", done, m_st == 2);
        check_eq("ptr", ptr, m_ptr);
        if (set_x || set_y || set_ab || set_cx) n_strobe++;
        if (done) n_done++;
        if (busy) n_busy++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_ptr"}, ptr, 5'd0);
        check_eq({tag, "_cfg_in"}, cfg_in, 8'h00);
        check_eq({tag, "_cfg_addr"}, cfg_addr, 3'd0);
        check_eq({tag, "_sets"}, {set_x, set_y, set_ab, set_cx}, 4'b0000);
    endtask

    initial begin
        int i;
        int guard;
        logic v;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset_model();
        clear_counts();
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Full load with in_valid held high; start during DONE is ignored.
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) tick(1'b1, 8'(k), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("full_strobes", n_strobe, 32);
        check_eq("full_done", n_done, 1);
        check_eq("full_busy_cycles", n_busy, 32);

        // Stalled stream starting in the first idle cycle after DONE.
        clear_counts();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("restart_busy", busy, 1'b1);
        i = 0;
        guard = 0;
        while (m_st != 0 && guard < 200) begin
            v = (guard % 3 == 0);
            tick(v, 8'(i), 1'b0, 1'b0);
            if (v) i++;
            guard++;
        end
        check_eq("stall_bound", guard < 200, 1'b1);
        check_eq("stall_strobes", n_strobe, 32);
        check_eq("stall_done", n_done, 1);

        // Abort after 10 accepted bytes with in_valid high in the abort cycle.
        clear_counts();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) tick(1'b1, 8'(k) ^ 8'hA5, 1'b0, 1'b0);
        tick(1'b1, 8'h55, 1'b0, 1'b1);
        tick(1'b1, 8'h66, 1'b0, 1'b0);
        check_eq("abort_strobes", n_strobe, 10);
        check_eq("abort_done", n_done, 0);
        check_eq("abort_ptr", ptr, 5'd0);

        // start pulsed mid-load at ptr=5 is ignored.
        clear_counts();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) tick(1'b1, 8'(k) ^ 8'h3C, k == 5, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("midstart_strobes", n_strobe, 32);
        check_eq("midstart_done", n_done, 1);

        // Async reset at ptr=17, asserted between clock edges.
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 17; k++) tick(1'b1, 8'(k) + 8'h40, 1'b0, 1'b0);
        check_eq("pre_rst_ptr", ptr, 5'd17);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        clear_counts();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'hC3, 1'b0, 1'b0);
        check_eq("rst_restart_x", set_x, 1'b1);
        for (int k = 1; k < 32; k++) tick(1'b1, 8'(k) + 8'hC3, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("rst_reload_strobes", n_strobe, 32);

        // start and abort together in IDLE: abort wins.
        tick(1'b1, 8'h99, 1'b1, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("start_abort_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
